mem_load_unit: RTL

Memory-stage load unit for the pipelined CPU: the return-path counterpart of the immediate extender. It issues word reads to data memory over a req/gnt/rvalid handshake, stalls the pipeline while the read is outstanding, extracts the addressed byte or half-word and sign- or zero-extends it to 32 bits for write-back. It sits between the MEM stage and the MEM/WB pipeline register and is the only block that drives data-memory reads.

---
 rtl/mem_load_unit_pkg.sv | 33 +++
 rtl/mem_load_unit_if.sv | 32 +++
 rtl/mem_load_unit_load_extend.sv | 52 +++++
 rtl/mem_load_unit.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mem_load_unit_pkg.sv
// mem_load_unit_pkg: shared definitions for the memory-stage load unit.
//   - LD_OP_* load operation codes (LD_OP_LENGTH bits wide)
//   - lsu_state_e FSM state encoding (LSU_ST_LENGTH bits wide)
//   - timeout counter width and a word-address helper
package mem_load_unit_pkg;

    localparam int unsigned LD_OP_LENGTH = 3;

    // Codes follow the RV32I funct3 encoding of the load instructions.
    localparam logic [LD_OP_LENGTH-1:0] LD_OP_LB  = 3'b000;
    localparam logic [LD_OP_LENGTH-1:0] LD_OP_LH  = 3'b001;
    localparam logic [LD_OP_LENGTH-1:0] LD_OP_LW  = 3'b010;
    localparam logic [LD_OP_LENGTH-1:0] LD_OP_LBU = 3'b100;
    localparam logic [LD_OP_LENGTH-1:0] LD_OP_LHU = 3'b101;

    localparam int unsigned LSU_ST_LENGTH = 3;

    typedef enum logic [LSU_ST_LENGTH-1:0] {
        LsuStIdle  = 3'd0,
        LsuStReq   = 3'd1,
        LsuStWait  = 3'd2,
        LsuStDone  = 3'd3,
        LsuStDrain = 3'd4
    } lsu_state_e;

    // Wide enough for the largest legal timeout (255).
    localparam int unsigned CNT_WIDTH = 8;

    function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
        return {byte_addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_load_unit_if.sv
// mem_load_unit_if: data-memory read port (req/gnt/rvalid handshake).
//   req    : read request, held until gnt
//   addr   : word-aligned read address
//   gnt    : request accepted this cycle
//   rvalid : rdata valid this cycle
//   rdata  : read word, little-endian byte lanes
// master = load unit, slave = data memory.
interface mem_load_unit_if;

    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );

endinterface

// File: rtl/mem_load_unit_load_extend.sv
// mem_load_unit_load_extend: combinational lane extraction and extension.
//   rdata      in  32  read word from memory
//   addr_lo    in  2   byte offset within the word
//   ld_op      in  3   load operation code
//   data       out 32  extracted, sign/zero-extended result (LW: raw word)
//   misaligned out 1   LH/LHU on an odd address, LW on a non-word address
module mem_load_unit_load_extend
    import mem_load_unit_pkg::*;
(
    input  logic [31:0]             rdata,
    input  logic [1:0]              addr_lo,
    input  logic [LD_OP_LENGTH-1:0] ld_op,
    output logic [31:0]             data,
    output logic                    misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        unique case (addr_lo)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data       = rdata;
        misaligned = 1'b0;
        case (ld_op)
            LD_OP_LB:  data = {{24{byte_sel[7]}}, byte_sel};
            LD_OP_LBU: data = {24'h0, byte_sel};
            LD_OP_LH: begin
                data       = {{16{half_sel[15]}}, half_sel};
                misaligned = addr_lo[0];
            end
            LD_OP_LHU: begin
                data       = {16'h0, half_sel};
                misaligned = addr_lo[0];
            end
            LD_OP_LW: misaligned = |addr_lo;
            // Undefined codes pass the raw word and never fault.
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_load_unit.sv
// mem_load_unit: memory-stage load unit. Issues word reads to data memory,
// stalls the pipeline while a read is outstanding, and returns the extended
// byte/half/word for write-back.
//   clk, rst_n   clock; asynchronous active-low reset
//   ld_valid     MEM stage presents a load
//   ld_op        LB/LBU/LH/LHU/LW code
//   ld_addr      byte address
//   ld_rd        destination register (passed through to wb_rd)
//   flush        kill the presented or in-flight load
//   mem          data-memory read port (master side)
//   stall        hold IF..MEM (combinational)
//   wb_valid     one-cycle pulse, wb_data/wb_rd valid
//   wb_rd        destination register
//   wb_data      extended load result
//   ld_err       one-cycle pulse: misaligned access or timeout
module mem_load_unit
    import mem_load_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ld_valid,
    input  logic [LD_OP_LENGTH-1:0] ld_op,
    input  logic [31:0]             ld_addr,
    input  logic [4:0]              ld_rd,
    input  logic                    flush,
    mem_load_unit_if.master         mem,
    output logic                    stall,
    output logic                    wb_valid,
    output logic [4:0]              wb_rd,
    output logic [31:0]             wb_data,
    output logic                    ld_err
);

    localparam logic [CNT_WIDTH-1:0] TmoLast = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    lsu_state_e              state_q, state_d;
    logic [LD_OP_LENGTH-1:0] op_q, op_d;
    logic [31:0]             addr_q, addr_d;
    logic [4:0]              rd_q, rd_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    wb_valid_q, wb_valid_d;
    logic [31:0]             wb_data_q, wb_data_d;
    logic                    ld_err_q, ld_err_d;

    logic                    in_idle;
    logic [1:0]              ext_addr_lo;
    logic [LD_OP_LENGTH-1:0] ext_op;
    logic [31:0]             ext_data;
    logic                    misaligned;
    logic                    timeout;

    // In IDLE the extender checks alignment of the presented load; otherwise it
    // extracts from the returning word using the captured op/address.
    assign in_idle     = (state_q == LsuStIdle);
    assign ext_addr_lo = in_idle ? ld_addr[1:0] : addr_q[1:0];
    assign ext_op      = in_idle ? ld_op : op_q;
    assign timeout     = (cnt_q >= TmoLast);

    mem_load_unit_load_extend u_load_extend (
        .rdata      (mem.rdata),
        .addr_lo    (ext_addr_lo),
        .ld_op      (ext_op),
        .data       (ext_data),
        .misaligned (misaligned)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        wb_valid_d = 1'b0;
        wb_data_d  = wb_data_q;
        ld_err_d   = 1'b0;
        stall      = 1'b0;

        unique case (state_q)
            LsuStIdle: begin
                if (ld_valid && !flush) begin
                    if (misaligned) begin
                        ld_err_d = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        op_d    = ld_op;
                        addr_d  = ld_addr;
                        rd_d    = ld_rd;
                        cnt_d   = '0;
                        state_d = LsuStReq;
                    end
                end
            end
            LsuStReq: begin
                stall = 1'b1;
                // rvalid alongside gnt is outside the memory contract and ignored.
                if (mem.gnt) begin
                    cnt_d   = cnt_q + CNT_WIDTH'(1);
                    state_d = flush ? LsuStDrain : LsuStWait;
                end else if (flush) begin
                    state_d = LsuStIdle;
                end else if (timeout) begin
                    ld_err_d = 1'b1;
                    state_d  = LsuStDone;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            LsuStWait: begin
                stall = 1'b1;
                // Data arriving with a flush is still written back.
                if (mem.rvalid) begin
                    wb_data_d  = ext_data;
                    wb_valid_d = 1'b1;
                    state_d    = LsuStDone;
                end else if (flush) begin
                    state_d = LsuStDrain;
                end else if (timeout) begin
                    ld_err_d = 1'b1;
                    state_d  = LsuStDone;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            LsuStDone: begin
                state_d = LsuStIdle;
            end
            LsuStDrain: begin
                // A granted read must be absorbed before a new request goes out.
                stall = ld_valid;
                if (mem.rvalid) begin
                    state_d = LsuStIdle;
                end
            end
            default: state_d = LsuStIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LsuStIdle;
            op_q       <= '0;
            addr_q     <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            ld_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            ld_err_q   <= ld_err_d;
        end
    end

    assign mem.req  = (state_q == LsuStReq);
    assign mem.addr = word_addr(addr_q);
    assign wb_valid = wb_valid_q;
    assign wb_data  = wb_data_q;
    assign wb_rd    = rd_q;
    assign ld_err   = ld_err_q;

endmodule
